// File: rtl/moving_avg_filter.sv
// Multi-channel boxcar moving-average filter with an exact running-sum accumulator.
// Handshaked in/out, one-cycle latency, bypass, synchronous history clear and a primed flag.
module moving_avg_filter #(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3,
  parameter int CHANNELS  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         bypass,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         primed
);

  localparam int N     = 1 << LOG2_TAPS;
  localparam int ACC_W = DATA_W + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] FILL_FULL = (LOG2_TAPS + 1)'(N);

  logic                        wipe;
  logic                        accept;
  logic [LOG2_TAPS-1:0]        wp_reg;
  logic [LOG2_TAPS:0]          fill_reg;
  logic [LOG2_TAPS:0]          fill_next;
  logic                        primed_reg;
  logic                        out_valid_reg;
  logic [CHANNELS*DATA_W-1:0]  out_data_reg;
  logic [CHANNELS*DATA_W-1:0]  result;

  assign wipe      = reset | clear;
  assign in_ready  = ~wipe & (~out_valid_reg | out_ready);
  assign accept    = in_valid & in_ready;
  assign fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic signed [DATA_W-1:0] hist_reg [N];
      logic signed [ACC_W-1:0]  acc_reg;
      logic signed [ACC_W-1:0]  acc_next;
      logic signed [DATA_W-1:0] new_s;
      logic signed [DATA_W-1:0] old_s;

      assign new_s    = in_data[gi*DATA_W +: DATA_W];
      assign old_s    = hist_reg[wp_reg];
      // Add the incoming sample and retire the one it overwrites; the sum stays exact.
      assign acc_next = acc_reg + {{LOG2_TAPS{new_s[DATA_W-1]}}, new_s}
                                - {{LOG2_TAPS{old_s[DATA_W-1]}}, old_s};
      // Arithmetic shift gives floor division; the mean always fits in DATA_W.
      assign result[gi*DATA_W +: DATA_W] = bypass ? new_s : DATA_W'(acc_next >>> LOG2_TAPS);

      always_ff @(posedge clock) begin
        if (wipe) begin
          for (int i = 0; i < N; i++) hist_reg[i] <= '0;
          acc_reg <= '0;
        end else if (accept) begin
          hist_reg[wp_reg] <= new_s;
          acc_reg          <= acc_next;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (wipe) begin
      wp_reg        <= '0;
      fill_reg      <= '0;
      primed_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (accept) begin
      wp_reg        <= wp_reg + 1'b1;
      fill_reg      <= fill_next;
      primed_reg    <= (fill_next == FILL_FULL);
      out_valid_reg <= 1'b1;
      out_data_reg  <= result;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign primed    = primed_reg;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter: a window-sum reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_moving_avg_filter;
  localparam int DATA_W = 24;
  localparam int LOG2_TAPS = 3;
  localparam int CHANNELS = 2;
  localparam int N = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [CHANNELS*DATA_W-1:0] in_data = '0;
  logic bypass = 1'b0;
  logic clear = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [CHANNELS*DATA_W-1:0] out_data;
  logic primed;

  int n_checks = 0;
  int n_fail = 0;

  moving_avg_filter #(.DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS), .CHANNELS(CHANNELS)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bypass(bypass), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .primed(primed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint chan(input logic [CHANNELS*DATA_W-1:0] v, input int c);
    logic [DATA_W-1:0] s;
    s = v[c*DATA_W +: DATA_W];
    return longint'($signed(s));
  endfunction

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / N;
    if (s < 0 && q * N != s) q = q - 1;
    return q;
  endfunction

  // Reference model: plain window of the last N accepted samples per channel.
  int hist0[$];
  int hist1[$];
  int n_accepted = 0;
  bit exp_valid = 0;
  bit exp_primed = 0;
  longint exp_d0 = 0;
  longint exp_d1 = 0;
  int outs0[$];
  int outs1[$];

  function automatic longint window_mean(input int h[$]);
    longint s = 0;
    foreach (h[i]) s += h[i];
    return floor_div(s);
  endfunction

  always @(negedge clock) begin
    bit exp_ready;
    bit acc;
    exp_ready = !reset && !clear && (!exp_valid || out_ready);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    chk("primed", primed, exp_primed);
    chk("out_data_ch0", chan(out_data, 0), exp_d0);
    chk("out_data_ch1", chan(out_data, 1), exp_d1);
    if (out_valid && out_ready) begin
      outs0.push_back(int'(chan(out_data, 0)));
      outs1.push_back(int'(chan(out_data, 1)));
      $display("out[%0d] ch0=%0d ch1=%0d primed=%0b", outs0.size() - 1,
               chan(out_data, 0), chan(out_data, 1), primed);
    end
    acc = in_valid && exp_ready;
    if (reset || clear) begin
      hist0.delete(); hist1.delete();
      n_accepted = 0; exp_valid = 0; exp_primed = 0; exp_d0 = 0; exp_d1 = 0;
    end else if (acc) begin
      hist0.push_back(int'(chan(in_data, 0)));
      hist1.push_back(int'(chan(in_data, 1)));
      if (hist0.size() > N) begin void'(hist0.pop_front()); void'(hist1.pop_front()); end
      n_accepted++;
      exp_primed = (n_accepted >= N);
      exp_valid = 1;
      exp_d0 = bypass ? chan(in_data, 0) : window_mean(hist0);
      exp_d1 = bypass ? chan(in_data, 1) : window_mean(hist1);
    end else if (out_ready) begin
      exp_valid = 0;
    end
  end

  task automatic send(input int a, input int b, input bit bp);
    bit done;
    done = 0;
    in_valid = 1;
    in_data = {b[DATA_W-1:0], a[DATA_W-1:0]};
    bypass = bp;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clock);
      done = in_ready;
      @(posedge clock);
      #1;
    end
    chk("send_accepted", done, 1);
    in_valid = 0;
    bypass = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1;
    @(posedge clock);
    #1;
    clear = 0;
    out_ready = 1;
    outs0.delete();
    outs1.delete();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_primed", primed, 0);
    reset = 0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // Step response
    for (int i = 1; i <= 10; i++) begin
      send(800, -800, 0);
      if (i == 7) chk("step_primed_7", primed, 0);
      if (i == 8) chk("step_primed_8", primed, 1);
    end
    drain();
    chk("step_out0", outs0[0], 100);
    chk("step_out0_ch1", outs1[0], -100);
    chk("step_out3", outs0[3], 400);
    chk("step_out7_ch1", outs1[7], -800);
    chk("step_out9", outs0[9], 800);

    // Floor rounding
    pulse_clear();
    send(-1, 0, 0);
    for (int i = 0; i < 9; i++) send(0, 0, 0);
    drain();
    chk("floor_neg_first", outs0[0], -1);
    chk("floor_neg_eighth", outs0[7], -1);
    chk("floor_neg_ninth", outs0[8], 0);
    pulse_clear();
    send(7, 0, 0);
    for (int i = 0; i < 8; i++) send(0, 0, 0);
    drain();
    chk("floor_pos_first", outs0[0], 0);
    chk("floor_pos_last", outs0[8], 0);

    // Full-scale swing
    pulse_clear();
    for (int i = 0; i < 20; i++) begin
      if (i < 9) send(8388607, -8388608, 0);
      else send(-8388608, 8388607, 0);
    end
    drain();
    chk("fs_steady", outs0[8], 8388607);
    chk("fs_first_drop", outs0[9], 6291455);
    chk("fs_second_drop", outs0[10], 4194303);
    chk("fs_floor", outs0[19], -8388608);
    chk("fs_ch1_ceiling", outs1[19], 8388607);

    // Backpressure
    pulse_clear();
    for (int i = 1; i <= 3; i++) send(16 * i, -16 * i, 0);
    out_ready = 0;
    in_valid = 1;
    in_data = {24'hFFFFC0, 24'h000040};
    for (int t = 0; t < 5; t++) begin
      @(negedge clock);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold_ch0", chan(out_data, 0), 12);
      @(posedge clock);
      #1;
    end
    out_ready = 1;
    for (int i = 4; i <= 12; i++) send(16 * i, -16 * i, 0);
    drain();
    chk("bp_count", outs0.size(), 12);
    chk("bp_out2", outs0[2], 12);
    chk("bp_out3", outs0[3], 20);
    chk("bp_out11", outs0[11], 136);
    chk("bp_out11_ch1", outs1[11], -136);

    // Bypass toggle
    pulse_clear();
    for (int i = 1; i <= 10; i++) send(10 * i, -10 * i, (i >= 4 && i <= 6));
    drain();
    chk("byp_out4", outs0[3], 40);
    chk("byp_out6", outs0[5], 60);
    chk("byp_out4_ch1", outs1[3], -40);
    chk("byp_out7", outs0[6], 35);
    chk("byp_out7_ch1", outs1[6], -35);
    chk("byp_out10", outs0[9], 65);

    // Clear mid-stream
    pulse_clear();
    for (int i = 0; i < 12; i++) send(800, -800, 0);
    chk("pre_clear_primed", primed, 1);
    chk("pre_clear_valid", out_valid, 1);
    clear = 1;
    in_valid = 1;
    in_data = {24'hFFFCE0, 24'h000320};
    #1;
    chk("clear_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    clear = 0;
    in_valid = 0;
    chk("clear_out_valid", out_valid, 0);
    chk("clear_primed", primed, 0);
    outs0.delete();
    outs1.delete();
    send(800, -800, 0);
    drain();
    chk("clear_restart", outs0[0], 100);
    chk("clear_restart_ch1", outs1[0], -100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
